// File: rtl/huc6261_pkg.sv
// Shared definitions for the HuC6261 palette access controller.
//   - CPU data-register indices (selected through rsel)
//   - pal_wr_t: one buffered CPU palette write
//   - gnt_e:    owner of the palette RAM slot in a CE cycle
package huc6261_pkg;

    localparam logic [4:0] REG_CTRL  = 5'h00;
    localparam logic [4:0] REG_ADDR  = 5'h01;
    localparam logic [4:0] REG_WDATA = 5'h02;
    localparam logic [4:0] REG_RDATA = 5'h03;
    localparam logic [4:0] REG_PERF  = 5'h04;

    typedef struct packed {
        logic [8:0]  addr;
        logic [15:0] data;
    } pal_wr_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_VID,
        GNT_WR,
        GNT_PF
    } gnt_e;

endpackage

// File: rtl/huc6261_wr_fifo.sv
// Synchronous FIFO of pending CPU palette writes.
// Ports:
//   CLK, RESn    clock, async active-low reset
//   ce           clock enable; pointers move only when ce=1
//   push, wdata  enqueue; caller must not push while full unless it pops too
//   pop, rdata   dequeue; rdata is the head entry (valid while !empty)
//   full, empty  occupancy flags
// Push and pop in the same cycle are both honoured, so a full FIFO that
// pops this cycle can still accept a push (the slot is freed at the edge).
module huc6261_wr_fifo
    import huc6261_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    CLK,
    input  logic    RESn,
    input  logic    ce,
    input  logic    push,
    input  pal_wr_t wdata,
    input  logic    pop,
    output pal_wr_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    pal_wr_t        mem [DEPTH];
    logic [PW:0]    wptr, rptr;   // extra MSB distinguishes full from empty

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (ce) begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (ce && push) mem[wptr[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[PW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/huc6261_pal_ctrl.sv
// HuC6261 palette access controller: shares one single-port 512x16 palette
// RAM between video scanout and the CPU indirect register port.
// Ports:
//   CLK, RESn, CE        clock, async active-low reset, clock enable
//   CSn, WRn, RDn, A2    CPU bus (A2=0 register select/status, A2=1 data)
//   DI, DO               CPU data; DO is 0 unless ~CSn & ~RDn
//   VID_REQ, VID_IDX     scanout lookup request (highest priority)
//   VID_DATA, VID_VALID  lookup result, one CE after the grant
//   RAM_ADDR/WE/WDATA    palette RAM slot for this CE cycle
//   RAM_RDATA            RAM read data, one CE after the address
// Build option: define HUC6261_PAL_PERF_EN to add a saturating count of CE
// cycles where CPU work was pending but video took the slot (rsel 0x04).
// The RAM slot is driven combinationally from this cycle's grant so that
// read data returns one CE later; when idle the last address is held.
module huc6261_pal_ctrl
    import huc6261_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 9
) (
    input  logic              CLK,
    input  logic              RESn,
    input  logic              CE,
    input  logic              CSn,
    input  logic              WRn,
    input  logic              RDn,
    input  logic              A2,
    input  logic [15:0]       DI,
    output logic [15:0]       DO,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_IDX,
    output logic [15:0]       VID_DATA,
    output logic              VID_VALID,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [15:0]       RAM_WDATA,
    input  logic [15:0]       RAM_RDATA
);

    logic [4:0]        rsel;
    logic [ADDR_W-1:0] addr;
    logic              rd_valid, overflow, pf_inflight, vid_pend;
    logic [15:0]       rd_buf, vid_hold, ram_wdata_q, perf_rd;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              wr_prev, rd_prev;
    gnt_e              gnt;

    // One access per strobe: act on the first CE sample of an asserted strobe.
    logic wr_act, rd_act, wr_stb, rd_stb;
    assign wr_act = ~CSn & ~WRn;
    assign rd_act = ~CSn & ~RDn;
    assign wr_stb = CE & wr_act & ~wr_prev;
    assign rd_stb = CE & rd_act & ~rd_prev;

    logic sel_wr, wr_ctrl, wr_addr, wr_wdata, rd_rdata;
    assign sel_wr   = wr_stb & ~A2;
    assign wr_ctrl  = wr_stb & A2 & (rsel == REG_CTRL);
    assign wr_addr  = wr_stb & A2 & (rsel == REG_ADDR);
    assign wr_wdata = wr_stb & A2 & (rsel == REG_WDATA);
    assign rd_rdata = rd_stb & A2 & (rsel == REG_RDATA);

    // Write FIFO
    pal_wr_t f_head, f_in;
    logic    f_push, f_pop, f_full, f_empty, wr_drop;

    assign f_in    = '{addr: addr, data: DI};
    assign f_pop   = (gnt == GNT_WR);
    assign f_push  = wr_wdata & (~f_full | f_pop);
    assign wr_drop = wr_wdata & f_full & ~f_pop;

    huc6261_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESn  (RESn),
        .ce    (CE),
        .push  (f_push),
        .wdata (f_in),
        .pop   (f_pop),
        .rdata (f_head),
        .full  (f_full),
        .empty (f_empty)
    );

    // Prefetch only with the FIFO empty so reads observe all earlier writes.
    logic pf_want;
    assign pf_want = (rsel == REG_RDATA) & ~rd_valid & f_empty & ~pf_inflight;

    // Slot arbitration; RESn gating keeps the RAM port quiet during reset.
    always_comb begin
        gnt = GNT_IDLE;
        if (CE && RESn) begin
            if (VID_REQ)       gnt = GNT_VID;
            else if (!f_empty) gnt = GNT_WR;
            else if (pf_want)  gnt = GNT_PF;
        end
    end

    always_comb begin
        RAM_ADDR  = ram_addr_q;
        RAM_WE    = 1'b0;
        RAM_WDATA = ram_wdata_q;
        case (gnt)
            GNT_VID: RAM_ADDR = VID_IDX;
            GNT_WR: begin
                RAM_ADDR  = f_head.addr;
                RAM_WE    = 1'b1;
                RAM_WDATA = f_head.data;
            end
            GNT_PF:  RAM_ADDR = addr;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            wr_prev     <= 1'b0;
            rd_prev     <= 1'b0;
            rsel        <= '0;
            addr        <= '0;
            rd_valid    <= 1'b0;
            rd_buf      <= '0;
            overflow    <= 1'b0;
            pf_inflight <= 1'b0;
            vid_pend    <= 1'b0;
            vid_hold    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else if (CE) begin
            wr_prev     <= wr_act;
            rd_prev     <= rd_act;
            ram_addr_q  <= RAM_ADDR;
            ram_wdata_q <= RAM_WDATA;
            vid_pend    <= (gnt == GNT_VID);
            pf_inflight <= (gnt == GNT_PF);
            if (vid_pend) vid_hold <= RAM_RDATA;

            if (sel_wr)           rsel     <= DI[4:0];
            if (wr_ctrl && DI[0]) overflow <= 1'b0;
            if (wr_drop)          overflow <= 1'b1;

            // Dropped FIFO writes still advance addr.
            if (wr_addr)
                addr <= DI[ADDR_W-1:0];
            else if (wr_wdata || (rd_rdata && rd_valid))
                addr <= addr + 1'b1;

            // A landing prefetch is discarded if addr is being rewritten.
            if (pf_inflight && !wr_addr) begin
                rd_buf   <= RAM_RDATA;
                rd_valid <= 1'b1;
            end else if (wr_addr || (rd_rdata && rd_valid)) begin
                rd_valid <= 1'b0;
            end
        end
    end

    assign VID_VALID = vid_pend;
    assign VID_DATA  = vid_pend ? RAM_RDATA : vid_hold;

`ifdef HUC6261_PAL_PERF_EN
    logic [15:0] perf_cnt;
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn)
            perf_cnt <= '0;
        else if (CE) begin
            if (wr_ctrl && DI[1])
                perf_cnt <= '0;
            else if (gnt == GNT_VID && (!f_empty || pf_want) && perf_cnt != 16'hFFFF)
                perf_cnt <= perf_cnt + 16'd1;
        end
    end
    assign perf_rd = perf_cnt;
`else
    assign perf_rd = '0;
`endif

    always_comb begin
        DO = '0;
        if (rd_act) begin
            if (!A2)
                DO = {8'b0, overflow, rd_valid, f_empty, rsel};
            else begin
                case (rsel)
                    REG_ADDR:  DO = {{(16-ADDR_W){1'b0}}, addr};
                    REG_RDATA: DO = rd_buf;
                    REG_PERF:  DO = perf_rd;
                    default:   DO = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huc6261_pal_ctrl.sv
// Directed bench for huc6261_pal_ctrl with a behavioural 512x16 palette RAM
// (registered read, one CE of latency). Inputs change 1 time unit after the
// rising edge; peeks of the combinational DO happen between edges so they
// never register as a CPU strobe.
module tb_huc6261_pal_ctrl;

    logic        CLK = 1'b0, RESn = 1'b0, CE = 1'b1;
    logic        CSn = 1'b1, WRn = 1'b1, RDn = 1'b1, A2 = 1'b0;
    logic [15:0] DI = '0, DO;
    logic        VID_REQ = 1'b0;
    logic [8:0]  VID_IDX = '0;
    logic [15:0] VID_DATA;
    logic        VID_VALID;
    logic [8:0]  RAM_ADDR;
    logic        RAM_WE;
    logic [15:0] RAM_WDATA, RAM_RDATA;

    int n_chk = 0, n_err = 0, we_in_vid = 0;
    logic [15:0] ram [512];
    logic [24:0] wlog [$];
    logic [15:0] v;

    huc6261_pal_ctrl dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .CSn(CSn), .WRn(WRn), .RDn(RDn),
        .A2(A2), .DI(DI), .DO(DO), .VID_REQ(VID_REQ), .VID_IDX(VID_IDX),
        .VID_DATA(VID_DATA), .VID_VALID(VID_VALID), .RAM_ADDR(RAM_ADDR),
        .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'h1000 + 16'(i);
        RAM_RDATA = '0;
    end

    always @(posedge CLK) begin
        if (CE) begin
            if (RAM_WE) begin
                ram[RAM_ADDR] <= RAM_WDATA;
                wlog.push_back({RAM_ADDR, RAM_WDATA});
                if (VID_REQ) we_in_vid++;
            end
            RAM_RDATA <= ram[RAM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        CSn = 1'b0; WRn = 1'b0; A2 = a; DI = d;
        tick();
        CSn = 1'b1; WRn = 1'b1;
        tick();
    endtask

    task automatic rd(input logic a, output logic [15:0] d);
        CSn = 1'b0; RDn = 1'b0; A2 = a;
        #1 d = DO;
        tick();
        CSn = 1'b1; RDn = 1'b1;
        tick();
    endtask

    task automatic peek(input logic a, output logic [15:0] d);
        CSn = 1'b0; RDn = 1'b0; A2 = a;
        #1 d = DO;
        CSn = 1'b1; RDn = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_vid_valid", VID_VALID, 0);
        check("rst_vid_data", VID_DATA, 0);
        check("rst_ram_we", RAM_WE, 0);
        check("rst_ram_addr", RAM_ADDR, 0);
        check("rst_ram_wdata", RAM_WDATA, 0);
        check("rst_do_idle", DO, 0);
        RESn = 1'b1;
        tick();
        peek(0, v); check("rst_status", v, 16'h0020);

        // Address wrap on consecutive wdata writes
        wr(0, 16'h0001); wr(1, 16'h01FF);
        wr(0, 16'h0002); wr(1, 16'h1234); wr(1, 16'h5678);
        check("wrap_nwr", wlog.size(), 2);
        check("wrap_w0", wlog[0], {9'h1FF, 16'h1234});
        check("wrap_w1", wlog[1], {9'h000, 16'h5678});
        wr(0, 16'h0001);
        rd(1, v); check("wrap_addr", v, 16'h0001);

        // Video starves CPU; FIFO overflows after 4
        wlog.delete();
        VID_IDX = 9'h1FF; VID_REQ = 1'b1;
        wr(0, 16'h0002);
        for (int i = 0; i < 6; i++) wr(1, 16'hC000 + 16'(i));
        peek(0, v); check("ovf_status", v, 16'h0082);
        check("ovf_vid_valid", VID_VALID, 1);
        check("ovf_vid_data", VID_DATA, 16'h1234);
        check("ovf_no_ram_wr", wlog.size(), 0);
        VID_REQ = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_we", RAM_WE, 1);
            check("drain_addr", RAM_ADDR, 9'(1 + i));
            tick();
        end
        check("drain_done_we", RAM_WE, 0);
        check("drain_nwr", wlog.size(), 4);
        for (int i = 0; i < 4; i++) check("drain_data", wlog[i], {9'(1 + i), 16'hC000 + 16'(i)});
        check("vid_hold_valid", VID_VALID, 0);
        check("vid_hold_data", VID_DATA, 16'h1234);
        check("we_during_vid", we_in_vid, 0);
        wr(0, 16'h0001); rd(1, v); check("ovf_addr", v, 16'h0007);
        wr(0, 16'h0000); wr(1, 16'h0001);
        peek(0, v); check("ovf_cleared", v, 16'h0020);

        // Single video lookup latency
        VID_IDX = 9'h000; VID_REQ = 1'b1;
        #1 check("vid_lat0", VID_VALID, 0);
        tick(); VID_REQ = 1'b0;
        #1 check("vid_lat1_valid", VID_VALID, 1);
        check("vid_lat1_data", VID_DATA, 16'h5678);
        tick();
        check("vid_lat2_valid", VID_VALID, 0);
        check("vid_lat2_data", VID_DATA, 16'h5678);

        // Prefetch of addr 0x010, read, auto-increment and next prefetch
        wr(0, 16'h0001); wr(1, 16'h0010);
        CSn = 1'b0; WRn = 1'b0; A2 = 1'b0; DI = 16'h0003;
        tick();
        CSn = 1'b1; WRn = 1'b1;
        #1 check("pf_issue_addr", RAM_ADDR, 9'h010);
        check("pf_issue_we", RAM_WE, 0);
        peek(0, v); check("pf_t0_status", v, 16'h0023);
        tick(); peek(0, v); check("pf_t1_status", v, 16'h0023);
        tick(); peek(0, v); check("pf_t2_status", v, 16'h0063);
        rd(1, v); check("pf_read", v, 16'h1010);
        peek(1, v); check("pf_stale", v, 16'h1010);
        tick();
        peek(0, v); check("pf2_status", v, 16'h0063);
        peek(1, v); check("pf2_data", v, 16'h1011);
        wr(0, 16'h0001); peek(1, v); check("pf_addr_inc", v, 16'h0011);

        // Read-after-write: prefetch waits for FIFO drain
        VID_IDX = 9'h1FF; VID_REQ = 1'b1;
        wr(1, 16'h0020); wr(0, 16'h0002); wr(1, 16'hABCD);
        wr(0, 16'h0001); wr(1, 16'h0020); wr(0, 16'h0003);
        peek(0, v); check("raw_blocked", v, 16'h0003);
        check("raw_vid_addr", RAM_ADDR, 9'h1FF);
        VID_REQ = 1'b0;
        #1 check("raw_drain_we", RAM_WE, 1);
        check("raw_drain_addr", RAM_ADDR, 9'h020);
        check("raw_drain_data", RAM_WDATA, 16'hABCD);
        tick();
        check("raw_pf_we", RAM_WE, 0);
        check("raw_pf_addr", RAM_ADDR, 9'h020);
        tick(); tick();
        peek(0, v); check("raw_status", v, 16'h0063);
        peek(1, v); check("raw_data", v, 16'hABCD);

        // A held strobe is one access
        wlog.delete();
        wr(0, 16'h0001); wr(1, 16'h0100); wr(0, 16'h0002);
        CSn = 1'b0; WRn = 1'b0; A2 = 1'b1; DI = 16'h7777;
        repeat (4) tick();
        CSn = 1'b1; WRn = 1'b1;
        tick();
        check("hold_nwr", wlog.size(), 1);
        wr(0, 16'h0001); peek(1, v); check("hold_addr", v, 16'h0101);

        // Unused/ctrl reads and CE gating
        wr(0, 16'h0007); peek(1, v); check("rsel7_read", v, 0);
        wr(0, 16'h0000); peek(1, v); check("ctrl_read", v, 0);
        CE = 1'b0;
        CSn = 1'b0; WRn = 1'b0; A2 = 1'b0; DI = 16'h0009;
        repeat (2) tick();
        CSn = 1'b1; WRn = 1'b1;
        tick(); CE = 1'b1; tick();
        peek(0, v); check("ce_gated", v, 16'h0020);

`ifdef HUC6261_PAL_PERF_EN
        VID_IDX = 9'h000; VID_REQ = 1'b1;
        wr(0, 16'h0002);
        for (int i = 0; i < 3; i++) wr(1, 16'h0E00 + 16'(i));
        wr(0, 16'h0000);
        CSn = 1'b0; WRn = 1'b0; A2 = 1'b1; DI = 16'h0002;
        tick();
        CSn = 1'b1; WRn = 1'b1;
        repeat (5) tick();
        VID_REQ = 1'b0;
        repeat (4) tick();
        wr(0, 16'h0004); peek(1, v); check("perf_count", v, 16'd5);
        wr(0, 16'h0000); wr(1, 16'h0002); wr(0, 16'h0004);
        peek(1, v); check("perf_clear", v, 0);
`else
        wr(0, 16'h0004); peek(1, v); check("perf_absent", v, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/huc6261_pal_ctrl.md
Name: huc6261_pal_ctrl

Overview:
Palette access controller for the HuC6261 video encoder. It arbitrates one single-port 512x16 palette RAM between the video scanout lookup and the CPU register interface. The CPU side uses HuC6261-style indirect addressing: A2=0 selects a register, A2=1 accesses it. CPU writes are buffered in a small FIFO and CPU reads are served from a prefetch register, so scanout never stalls.

Parameters:
FIFO_DEPTH, 4, CPU write FIFO entries (power of 2, >=2)
ADDR_W, 9, palette address width (512 entries)

Ports:
CLK  in  1  system clock
RESn  in  1  reset, asynchronous, active-low
CE  in  1  clock enable; all state advances only when CE=1
CSn  in  1  chip select, active-low
WRn  in  1  write strobe, active-low
RDn  in  1  read strobe, active-low
A2  in  1  0=register select/status, 1=data port
DI  in  16  CPU write data
DO  out  16  CPU read data; 0 when not (~CSn & ~RDn)
VID_REQ  in  1  scanout lookup request this CE cycle
VID_IDX  in  9  palette index for scanout
VID_DATA  out  16  palette entry returned to scanout
VID_VALID  out  1  VID_DATA valid
RAM_ADDR  out  9  palette RAM address
RAM_WE  out  1  palette RAM write enable
RAM_WDATA  out  16  palette RAM write data
RAM_RDATA  in  16  palette RAM read data, registered, 1 CE of latency

Behaviour:
- Reset (async, RESn=0): rsel=0, addr=0, FIFO empty, rd_valid=0, overflow=0, VID_VALID=0, VID_DATA=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0. DO is combinational and forced to 0 when not selected.
- CPU accesses act once per strobe, on the first CE cycle of ~CSn&~WRn (or ~RDn), detected as an edge against the previous CE sample. A strobe held for N cycles counts as 1 access.
- A2=0 write: rsel <= DI[4:0]. A2=0 read: DO = {8'b0, overflow, rd_valid, fifo_empty, rsel}.
- Data registers (A2=1, by rsel):
  - 0x00 ctrl. Write DI[0]=1 clears overflow. Reads return 0.
  - 0x01 addr. Write: addr <= DI[8:0], rd_valid <= 0. Read returns {7'b0, addr}.
  - 0x02 wdata. Write pushes {addr, DI} to the FIFO, then addr++. If the FIFO is full, the write is dropped and overflow is set, but addr still increments.
  - 0x03 rdata. Read returns the prefetch buffer. If rd_valid=1: addr++, rd_valid <= 0. If rd_valid=0: returns stale data and addr does not change.
  - Other rsel: writes ignored, reads 0.
- addr increments wrap 511 -> 0.
- Arbitration, one RAM slot per CE, in strict priority:
  - (1) VID_REQ: RAM_ADDR = VID_IDX, RAM_WE = 0.
  - (2) FIFO not empty: pop the head, RAM_WE = 1.
  - (3) rsel==3, rd_valid=0, FIFO empty, no prefetch in flight: issue a prefetch read of addr.
  - (4) Otherwise idle: RAM_WE = 0, RAM_ADDR holds.
- Prefetch is issued only with the FIFO empty, so a read always sees earlier CPU writes.
- Prefetch data lands one CE after issue and sets rd_valid. If addr was rewritten while the prefetch was in flight, the result is discarded.
- VID_VALID is asserted exactly one CE after a granted VID_REQ, with VID_DATA = RAM_RDATA. Otherwise VID_VALID=0 and VID_DATA holds its value.
- A FIFO push and pop in the same CE are both allowed; the count is unchanged. A full FIFO with a simultaneous pop accepts the push.
- Continuous VID_REQ starves the CPU indefinitely; this is by design, since the horizontal blank frees slots.

Optional Feature:
HUC6261_PAL_PERF_EN. When defined, adds a 16-bit saturating counter of CE cycles in which the FIFO or a prefetch was pending but the slot went to video. It is readable at rsel 0x04, and a ctrl write with DI[1]=1 clears it. When undefined, rsel 0x04 reads 0 and no counter logic is present.

Decomposition:
- Package huc6261_pkg holds:
  - register index localparams (REG_CTRL, REG_ADDR, REG_WDATA, REG_RDATA, REG_PERF);
  - typedef pal_wr_t {logic [8:0] addr; logic [15:0] data;};
  - typedef enum of the arbiter grant {GNT_IDLE, GNT_VID, GNT_WR, GNT_PF}.
- Sub-module huc6261_wr_fifo: a synchronous FIFO of pal_wr_t with full/empty flags and simultaneous push/pop.

Test Plan:
- Reset then status read (A2=0, rsel=0): DO=0x0020 (fifo_empty=1). VID_VALID=0.
- Select 0x01, write 0x1FF. Select 0x02, write 0x1234, then 0x5678 → RAM writes to addr 0x1FF=0x1234 and 0x000=0x5678 (wrap). Then read reg 0x01 → 0x0001.
- Hold VID_REQ=1 for 10 CE while pushing 6 writes → first 4 buffered, overflow=1, zero RAM_WE during VID_REQ. After release, 4 writes drain in 4 consecutive CE.
- Addr=0x010, select 0x03 → prefetch issued, rd_valid=1 two CE later. Read → RAM[0x010] returned, addr=0x011, next prefetch of 0x011 follows.
- Write 0xABCD to 0x020 via wdata, then immediately set addr=0x020 and select rdata → prefetch waits for the FIFO to drain, read returns 0xABCD.
- With HUC6261_PAL_PERF_EN: 3 writes pending, VID_REQ for 5 CE → rsel 0x04 reads 5. Ctrl write DI=0x0002 → reads 0.
